// File: rtl/audio_sample_pico_feeder.sv
// Audio sample to PicoBlaze feeder: signed 16-bit sample -> 8-bit magnitude -> FIFO -> strobed byte.
// Optional window-peak reduction is enabled by defining PEAK_HOLD_EN.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | waiting for a buffered byte; pops the FIFO head when level != 0
// PRESENT | new byte on input_data, clk_readdata high for this one cycle
// HOLD    | input_data frozen while the ISR reads it; counts down to 0
module audio_sample_pico_feeder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int PEAK_WINDOW    = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sample_valid,
  input  logic [15:0]                   sample_data,
  input  logic                          clr_overflow,
  output logic [7:0]                    input_data,
  output logic                          clk_readdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          pop;

  logic [15:0]   mag;
  logic [7:0]    mag_byte;
  logic          mag_unused;

  logic          offer_valid;
  logic [7:0]    offer_byte;
  logic          wr_en;
  logic          drop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // -32768 has no positive counterpart in 16 bits, so it clamps to full scale
  always_comb begin
    if (sample_data == 16'h8000)
      mag = 16'h7FFF;
    else if (sample_data[15])
      mag = 16'h0000 - sample_data;
    else
      mag = sample_data;
  end

  assign mag_byte   = mag[14:7];
  assign mag_unused = ^{mag[15], mag[6:0]};

`ifdef PEAK_HOLD_EN
  localparam int WW = (PEAK_WINDOW > 1) ? $clog2(PEAK_WINDOW) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(PEAK_WINDOW - 1);

  logic [WW-1:0] win_cnt;
  logic [7:0]    peak, peak_nxt;

  assign peak_nxt    = (mag_byte > peak) ? mag_byte : peak;
  assign offer_valid = sample_valid && (win_cnt == WIN_LAST);
  assign offer_byte  = peak_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt <= '0;
      peak    <= '0;
    end else if (sample_valid) begin
      if (win_cnt == WIN_LAST) begin
        win_cnt <= '0;
        peak    <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        peak    <= peak_nxt;
      end
    end
  end
`else
  localparam int peak_window_unused = PEAK_WINDOW;

  assign offer_valid = sample_valid;
  assign offer_byte  = mag_byte;
`endif

  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign wr_en = offer_valid && ((fifo_level != DEPTH_L) || pop);
  assign drop  = offer_valid && !wr_en;

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          pop       = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        hold_cnt_nxt = HOLD_LOAD;
        state_nxt    = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0)
          state_nxt = IDLE;
        else
          hold_cnt_nxt = hold_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt     <= '0;
      input_data   <= '0;
      clk_readdata <= 1'b0;
    end else begin
      hold_cnt     <= hold_cnt_nxt;
      clk_readdata <= pop;
      if (pop)
        input_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= offer_byte;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // a drop in the same cycle as a clear leaves the flag set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clr_overflow)
      overflow <= 1'b0;
  end

endmodule

// File: tb/tb_audio_sample_pico_feeder.sv
// Directed bench for audio_sample_pico_feeder: expected bytes queued at stimulus time,
// checked against every clk_readdata strobe by a negedge monitor.
`timescale 1ns/1ps

module tb_audio_sample_pico_feeder;

  localparam int DEPTH = 4;
  localparam int HOLD  = 16;
  localparam int PW    = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        clr_overflow = 1'b0;
  logic [7:0]  input_data;
  logic        clk_readdata;
  logic [2:0]  fifo_level;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe = -1;
  int base;
  int k;

  logic       mon_en = 1'b0;
  logic       prev_strobe = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_q [$];

  logic [15:0] burst [6] = '{16'h0100, 16'hFE00, 16'h1000, 16'h7FFF, 16'h8001, 16'h2222};
  logic [15:0] peak_s [4] = '{16'h0100, 16'hF000, 16'h0080, 16'h0200};

  audio_sample_pico_feeder #(
    .FIFO_DEPTH    (DEPTH),
    .HOLDOFF_CYCLES(HOLD),
    .PEAK_WINDOW   (PW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .clr_overflow (clr_overflow),
    .input_data   (input_data),
    .clk_readdata (clk_readdata),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] mag_b(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return 8'(v / 128);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s, input bit push);
    sample_data  = s;
    sample_valid = 1'b1;
    if (push) exp_q.push_back(mag_b(s));
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_strobe) check("no_back_to_back", {31'b0, clk_readdata}, 32'd0);
      if (clk_readdata) begin
        strobe_cnt++;
        last_strobe = cyc;
        if (exp_q.size() == 0) check("strobe_with_empty_scoreboard", 32'(exp_q.size()), 32'd1);
        else check("strobe_data", {24'b0, input_data}, {24'b0, exp_q.pop_front()});
      end else if (input_data !== prev_data) begin
        check("data_stable", {24'b0, input_data}, {24'b0, prev_data});
      end
    end
    prev_strobe = clk_readdata;
    prev_data   = input_data;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_input_data", {24'b0, input_data}, 32'h0);
    check("rst_strobe", {31'b0, clk_readdata}, 32'h0);
    check("rst_level", {29'b0, fifo_level}, 32'h0);
    check("rst_overflow", {31'b0, overflow}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;

`ifndef PEAK_HOLD_EN
    // single sample latency and hold window
    k = cyc;
    send(16'h1234, 1'b1);
    wait_cyc(k + 2 + HOLD);
    check("t1_held_data", {24'b0, input_data}, 32'h24);
    wait_cyc(k + HOLD + 6);
    check("t1_strobe_cycle", last_strobe, k + 2);
    check("t1_strobe_count", strobe_cnt, 1);

    // magnitude corner values
    send(16'hFFFF, 1'b1);
    repeat (HOLD + 4) tick();
    check("t2_ffff", {24'b0, input_data}, 32'h00);
    send(16'h8000, 1'b1);
    repeat (HOLD + 4) tick();
    check("t2_8000", {24'b0, input_data}, 32'hFF);
    send(16'h0000, 1'b1);
    repeat (HOLD + 4) tick();
    check("t2_0000", {24'b0, input_data}, 32'h00);
    check("t2_strobe_count", strobe_cnt, 4);

    // back-to-back burst overflows the FIFO
    base = strobe_cnt;
    for (int i = 0; i < 6; i++) send(burst[i], i < 5);
    check("t3_overflow_set", {31'b0, overflow}, 32'h1);
    check("t3_level_full", {29'b0, fifo_level}, 32'd4);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t3_overflow_clr", {31'b0, overflow}, 32'h0);
    repeat (5 * (HOLD + 2) + 4) tick();
    check("t3_strobes", strobe_cnt - base, 5);
    check("t3_level_empty", {29'b0, fifo_level}, 32'd0);
    check("t3_queue_drained", 32'(exp_q.size()), 32'd0);

    // write into a full FIFO in the pop cycle
    base = strobe_cnt;
    k = cyc;
    for (int i = 0; i < 5; i++) send(16'h0400 * 16'(i + 1), 1'b1);
    wait_cyc(k + HOLD + 3);
    check("t4_level_before", {29'b0, fifo_level}, 32'd4);
    send(16'hC000, 1'b1);
    check("t4_level_after", {29'b0, fifo_level}, 32'd4);
    check("t4_no_overflow", {31'b0, overflow}, 32'h0);
    repeat (6 * (HOLD + 2)) tick();
    check("t4_strobes", strobe_cnt - base, 6);
    check("t4_queue_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset during HOLD with bytes buffered
    base = strobe_cnt;
    for (int i = 0; i < 4; i++) send(16'h0A00 + 16'(i * 256), i == 0);
    check("t5_level_before", {29'b0, fifo_level}, 32'd3);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_data", {24'b0, input_data}, 32'h0);
    check("t5_rst_strobe", {31'b0, clk_readdata}, 32'h0);
    check("t5_rst_level", {29'b0, fifo_level}, 32'h0);
    check("t5_rst_overflow", {31'b0, overflow}, 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;
    repeat (3 * (HOLD + 2)) tick();
    check("t5_no_strobe_after_rst", strobe_cnt - base, 1);
    send(16'h4000, 1'b1);
    repeat (HOLD + 4) tick();
    check("t5_new_sample_strobe", strobe_cnt - base, 2);
`endif

    // peak window reduction (or plain pass-through when disabled)
    base = strobe_cnt;
`ifdef PEAK_HOLD_EN
    exp_q.push_back(8'h20);
    for (int i = 0; i < 4; i++) send(peak_s[i], 1'b0);
    repeat (5 * (HOLD + 2)) tick();
    check("t6_peak_strobes", strobe_cnt - base, 1);
`else
    for (int i = 0; i < 4; i++) send(peak_s[i], 1'b1);
    repeat (5 * (HOLD + 2)) tick();
    check("t6_plain_strobes", strobe_cnt - base, 4);
`endif
    check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
